hazard_ctrl: RTL and testbench

//  Hazard and forwarding controller for the 5-stage pipelined CPU (IF/ID/EXE/MEM/WB).

---
 rtl/hazard_if.sv | 27 ++
 rtl/hazard_ctrl.sv | 84 ++++++++
 tb/tb_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// ID-stage <-> hazard controller bundle: decoded ID fields in, stall/forward selects out.
interface hazard_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic            id_use_rt;
    logic            id_wreg;
    logic            id_m2reg;
    logic [RA_W-1:0] id_dest;
    logic             stall;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rt, id_wreg, id_m2reg, id_dest,
        input  stall, fwda, fwdb, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rt, id_wreg, id_m2reg, id_dest,
        output stall, fwda, fwdb, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and operand forwarding control for a 5-stage pipeline.
// Shadows the destination of the instructions in EXE (slot E) and MEM (slot M).
module hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hif
);

    typedef struct packed {
        logic            v;
        logic            wr;
        logic            ld;
        logic [RA_W-1:0] dst;
    } slot_t;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_EXE  = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_LOAD = 2'b11
    } fwd_t;

    localparam slot_t            BUBBLE  = '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t            e_q, e_d;
    slot_t            m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;

    // Register 0 is hardwired, so it can never be a forwarding source.
    function automatic logic hit(input slot_t s, input logic [RA_W-1:0] r);
        return s.v & s.wr & (s.dst == r) & (r != '0);
    endfunction

    function automatic fwd_t fwd_sel(input slot_t e, input slot_t m,
                                     input logic [RA_W-1:0] r);
        if (hit(e, r) && !e.ld) return FWD_EXE;
        if (hit(m, r))          return m.ld ? FWD_LOAD : FWD_MEM;
        return FWD_RF;
    endfunction

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        stall = hif.id_valid & e_q.ld &
                (hit(e_q, hif.id_rs) | (hif.id_use_rt & hit(e_q, hif.id_rt)));

        hif.fwda = fwd_sel(e_q, m_q, hif.id_rs);
        hif.fwdb = FWD_RF;
        if (hif.id_use_rt) hif.fwdb = fwd_sel(e_q, m_q, hif.id_rt);

        e_d = BUBBLE;
        if (!stall) begin
            e_d.v   = hif.id_valid;
            e_d.wr  = hif.id_wreg;
            e_d.ld  = hif.id_m2reg;
            e_d.dst = hif.id_dest;
        end
        m_d = e_q;

        cnt_d = cnt_q;
        if (stall && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q   <= BUBBLE;
            m_q   <= BUBBLE;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
        end
    end

    assign hif.stall     = stall;
    assign hif.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus randomized traffic
// checked against an in-flight-writer queue model.
module tb_hazard_ctrl;

    localparam int RA_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_if #(.RA_W(RA_W), .CNT_W(16)) hif  ();
    hazard_if #(.RA_W(RA_W), .CNT_W(2))  hif2 ();

    hazard_ctrl #(.RA_W(RA_W), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .hif(hif.slave));
    hazard_ctrl #(.RA_W(RA_W), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .hif(hif2.slave));

    int errors = 0;
    int checks = 0;

    // Model: queue of in-flight writers, youngest (EXE) at index 0.
    typedef struct {
        bit wr;
        bit ld;
        int dst;
    } ent_t;

    ent_t q[$];
    int   m_cnt;
    bit   m_stall;
    int   m_fwda, m_fwdb;
    bit   dc_a, dc_b;
    bit   cur_v, cur_use_rt, cur_wreg, cur_m2reg;
    int   cur_rs, cur_rt, cur_dest;

    function automatic ent_t bubble();
        ent_t b;
        b.wr = 0; b.ld = 0; b.dst = 0;
        return b;
    endfunction

    // Youngest writer of r wins; a load still in EXE has no value to forward yet.
    task automatic model_fwd(input int r, output int sel, output bit dc);
        sel = 0;
        dc  = 0;
        if (r != 0) begin
            for (int i = 0; i < 2; i++) begin
                if (q[i].wr && q[i].dst == r) begin
                    if (i == 0 && q[i].ld) dc = 1;
                    else if (i == 0)       sel = 1;
                    else                   sel = q[i].ld ? 3 : 2;
                    break;
                end
            end
        end
    endtask

    task automatic step(input bit v, input int rs, input int rt, input bit use_rt,
                        input bit wreg, input bit m2reg, input int dest, input bit r);
        bit ua, ub;
        cur_v = v; cur_rs = rs; cur_rt = rt; cur_use_rt = use_rt;
        cur_wreg = wreg; cur_m2reg = m2reg; cur_dest = dest;
        rst = r;
        hif.id_valid  = v;      hif2.id_valid  = v;
        hif.id_rs     = rs[4:0]; hif2.id_rs    = rs[4:0];
        hif.id_rt     = rt[4:0]; hif2.id_rt    = rt[4:0];
        hif.id_use_rt = use_rt; hif2.id_use_rt = use_rt;
        hif.id_wreg   = wreg;   hif2.id_wreg   = wreg;
        hif.id_m2reg  = m2reg;  hif2.id_m2reg  = m2reg;
        hif.id_dest   = dest[4:0]; hif2.id_dest = dest[4:0];
        @(negedge clk);
        ua = (rs != 0) && q[0].wr && q[0].ld && q[0].dst == rs;
        ub = use_rt && (rt != 0) && q[0].wr && q[0].ld && q[0].dst == rt;
        m_stall = v && (ua || ub);
        model_fwd(rs, m_fwda, dc_a);
        if (use_rt) model_fwd(rt, m_fwdb, dc_b);
        else begin m_fwdb = 0; dc_b = 0; end
    endtask

    task automatic advance();
        ent_t n;
        @(posedge clk);
        if (rst) begin
            q = {};
            q.push_back(bubble());
            q.push_back(bubble());
            m_cnt = 0;
        end else begin
            if (m_stall) m_cnt++;
            n = bubble();
            if (!m_stall) begin
                n.wr = cur_v && cur_wreg;
                n.ld = cur_m2reg;
                n.dst = cur_dest;
            end
            q.push_front(n);
            void'(q.pop_back());
        end
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 1, 0, 0, 1, 1, 4, 1);          // lw $4 presented while in reset
        advance();
        step(1, 4, 4, 1, 1, 0, 6, 0);          // add $6,$4,$4
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", hif.stall); end
        checks++; if (hif.fwda !== 2'b00) begin errors++; $display("FAIL reset_fwda got=%0b exp=00", hif.fwda); end
        checks++; if (hif.fwdb !== 2'b00) begin errors++; $display("FAIL reset_fwdb got=%0b exp=00", hif.fwdb); end
        checks++; if (hif.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", hif.stall_cnt); end
        advance();
    endtask

    task automatic test_exe_forward();
        do_reset();
        step(1, 1, 2, 1, 1, 0, 3, 0);          // add $3,$1,$2
        advance();
        step(1, 3, 5, 1, 1, 0, 4, 0);          // sub $4,$3,$5
        checks++; if (hif.fwda !== 2'b01) begin errors++; $display("FAIL t1_fwda got=%0b exp=01", hif.fwda); end
        checks++; if (hif.fwdb !== 2'b00) begin errors++; $display("FAIL t1_fwdb got=%0b exp=00", hif.fwdb); end
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL t1_stall got=%0b exp=0", hif.stall); end
        advance();
    endtask

    task automatic test_load_use();
        do_reset();
        step(1, 1, 0, 0, 1, 1, 4, 0);          // lw $4,0($1)
        advance();
        step(1, 4, 4, 1, 1, 0, 6, 0);          // add $6,$4,$4
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL t2_stall got=%0b exp=1", hif.stall); end
        advance();
        step(1, 4, 4, 1, 1, 0, 6, 0);
        checks++; if (hif.stall_cnt !== 16'd1) begin errors++; $display("FAIL t2_cnt got=%0d exp=1", hif.stall_cnt); end
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL t2_stall2 got=%0b exp=0", hif.stall); end
        checks++; if (hif.fwda !== 2'b11) begin errors++; $display("FAIL t2_fwda got=%0b exp=11", hif.fwda); end
        checks++; if (hif.fwdb !== 2'b11) begin errors++; $display("FAIL t2_fwdb got=%0b exp=11", hif.fwdb); end
        advance();
    endtask

    task automatic test_youngest_wins();
        do_reset();
        step(1, 1, 2, 1, 1, 0, 5, 0);          // add $5
        advance();
        step(1, 3, 4, 1, 1, 0, 5, 0);          // add $5
        advance();
        step(1, 5, 5, 1, 1, 0, 7, 0);          // sub $7,$5,$5
        checks++; if (hif.fwda !== 2'b01) begin errors++; $display("FAIL t3_fwda got=%0b exp=01", hif.fwda); end
        checks++; if (hif.fwdb !== 2'b01) begin errors++; $display("FAIL t3_fwdb got=%0b exp=01", hif.fwdb); end
        advance();
        step(1, 5, 5, 0, 1, 0, 8, 0);          // $5 now in MEM (ALU); rt unused
        checks++; if (hif.fwda !== 2'b10) begin errors++; $display("FAIL t3_mem_fwda got=%0b exp=10", hif.fwda); end
        checks++; if (hif.fwdb !== 2'b00) begin errors++; $display("FAIL t3_unused_fwdb got=%0b exp=00", hif.fwdb); end
        advance();
    endtask

    task automatic test_reg_zero();
        do_reset();
        step(1, 1, 2, 1, 1, 0, 0, 0);          // add $0,$1,$2
        advance();
        step(1, 0, 0, 1, 1, 0, 4, 0);          // sub $4,$0,$0
        checks++; if (hif.fwda !== 2'b00) begin errors++; $display("FAIL t4_fwda got=%0b exp=00", hif.fwda); end
        checks++; if (hif.fwdb !== 2'b00) begin errors++; $display("FAIL t4_fwdb got=%0b exp=00", hif.fwdb); end
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL t4_stall got=%0b exp=0", hif.stall); end
        advance();
        step(1, 1, 0, 0, 1, 1, 0, 0);          // lw $0
        advance();
        step(1, 0, 0, 1, 1, 0, 6, 0);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL t4_lw0_stall got=%0b exp=0", hif.stall); end
        advance();
    endtask

    task automatic test_reset_during_stall();
        do_reset();
        step(1, 1, 0, 0, 1, 1, 4, 0);          // lw $4
        advance();
        step(1, 4, 1, 1, 1, 0, 6, 0);          // add $6,$4,$1
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL t5_pre_stall got=%0b exp=1", hif.stall); end
        rst = 1'b1;
        advance();
        step(1, 4, 1, 1, 1, 0, 6, 0);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL t5_stall got=%0b exp=0", hif.stall); end
        checks++; if (hif.fwda !== 2'b00) begin errors++; $display("FAIL t5_fwda got=%0b exp=00", hif.fwda); end
        checks++; if (hif.stall_cnt !== 16'd0) begin errors++; $display("FAIL t5_cnt got=%0d exp=0", hif.stall_cnt); end
        advance();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step(1, 1, 0, 0, 1, 1, 4, 0);      // lw $4
            advance();
            step(1, 4, 4, 1, 1, 0, 6, 0);      // dependent add: stalls
            advance();
            step(1, 4, 4, 1, 1, 0, 6, 0);
            checks++;
            if (hif2.stall_cnt !== 2'((k > 3) ? 3 : k)) begin
                errors++; $display("FAIL t6_cnt2 pair=%0d got=%0d exp=%0d", k, hif2.stall_cnt, (k > 3) ? 3 : k);
            end
            checks++;
            if (hif.stall_cnt !== 16'(k)) begin
                errors++; $display("FAIL t6_cnt16 pair=%0d got=%0d exp=%0d", k, hif.stall_cnt, k);
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3), $urandom_range(0, 59) == 0);
            checks++;
            if (hif.stall !== m_stall) begin
                errors++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, hif.stall, m_stall);
            end
            if (!m_stall && !dc_a) begin
                checks++;
                if (hif.fwda !== 2'(m_fwda)) begin
                    errors++; $display("FAIL rnd_fwda n=%0d got=%0d exp=%0d", n, hif.fwda, m_fwda);
                end
            end
            if (!m_stall && !dc_b) begin
                checks++;
                if (hif.fwdb !== 2'(m_fwdb)) begin
                    errors++; $display("FAIL rnd_fwdb n=%0d got=%0d exp=%0d", n, hif.fwdb, m_fwdb);
                end
            end
            checks++;
            if (hif.stall_cnt !== 16'(m_cnt)) begin
                errors++; $display("FAIL rnd_cnt16 n=%0d got=%0d exp=%0d", n, hif.stall_cnt, m_cnt);
            end
            checks++;
            if (hif2.stall_cnt !== 2'((m_cnt > 3) ? 3 : m_cnt)) begin
                errors++; $display("FAIL rnd_cnt2 n=%0d got=%0d exp=%0d", n, hif2.stall_cnt, (m_cnt > 3) ? 3 : m_cnt);
            end
            advance();
        end
    endtask

    initial begin
        q.push_back(bubble());
        q.push_back(bubble());
        m_cnt = 0;
        test_reset();
        test_exe_forward();
        test_load_use();
        test_youngest_wins();
        test_reg_zero();
        test_reset_during_stall();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
